// File: rtl/pattern_ticker_if.sv
// -----------------------------------------------------------------------------
// pattern_ticker_if
//   Control and status bundle of the pattern_ticker LED/heartbeat engine.
//
//   Signals (direction as seen by the engine, i.e. the slave modport):
//     mode      in   2      0=count up, 1=count down, 2=bounce, 3=rotate left
//     pause     in   1      level: freeze prescaler and pattern
//     step      in   1      1-cycle pulse: single advance while paused
//     override  in   WIDTH  switch value; nonzero replaces pattern on out
//     pattern   out  WIDTH  current sequencer value (registered)
//     out       out  WIDTH  override when nonzero, else pattern
//     tick      out  1      1-cycle pulse per advance (registered)
//     flipper   out  1      toggles on every advance
//
//   master: the controlling top level.  slave: pattern_ticker itself.
// -----------------------------------------------------------------------------
interface pattern_ticker_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       mode;
  logic             pause;
  logic             step;
  logic [WIDTH-1:0] override;
  logic [WIDTH-1:0] pattern;
  logic [WIDTH-1:0] out;
  logic             tick;
  logic             flipper;

  modport master (
    output mode, pause, step, override,
    input  pattern, out, tick, flipper
  );

  modport slave (
    input  mode, pause, step, override,
    output pattern, out, tick, flipper
  );
endinterface

// File: rtl/pattern_ticker.sv
// -----------------------------------------------------------------------------
// pattern_ticker
//   Parametrised LED/heartbeat pattern engine: a prescaler generates an
//   "advance" every TICKS cycles, the sequencer steps the pattern according to
//   the selected mode, a flipper toggles per advance, and a nonzero switch
//   override replaces the pattern on the output.
//
//   Parameters:
//     WIDTH     pattern/output width (>= 2)
//     TICKS     prescaler period in CLK cycles (>= 1)
//     TICK_W    prescaler counter width, 2**TICK_W > TICKS
//     ROT_INIT  seed loaded when rotate mode is entered
//
//   Ports:
//     CLK   system clock
//     RST   synchronous reset, active-high
//     bus   pattern_ticker_if.slave (mode/pause/step/override in,
//           pattern/out/tick/flipper out)
// -----------------------------------------------------------------------------
module pattern_ticker #(
  parameter int               WIDTH    = 8,
  parameter int               TICKS    = 100000000,
  parameter int               TICK_W   = 32,
  parameter logic [WIDTH-1:0] ROT_INIT = WIDTH'(1)
) (
  input logic              CLK,
  input logic              RST,
  pattern_ticker_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_UP     = 2'd0,
    MODE_DOWN   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_ROT    = 2'd3
  } mode_e;

  localparam logic [TICK_W-1:0] LAST = TICK_W'(TICKS - 1);

  logic [TICK_W-1:0] cnt_q;
  logic [WIDTH-1:0]  pattern_q;
  logic              dir_right_q;
  logic              tick_q;
  logic              flipper_q;
  mode_e             mode_q;

  mode_e             mode_d;
  logic              at_last;
  logic              advance;
  logic              mode_chg;
  logic              is_onehot;
  logic              eff_left;
  logic [WIDTH-1:0]  shifted;
  logic [WIDTH-1:0]  next_pattern;
  logic              next_dir_right;
  logic [WIDTH-1:0]  reinit_pattern;

  assign mode_d   = mode_e'(bus.mode);
  assign at_last  = (cnt_q == LAST);
  // While paused only a step pulse advances; while running step is ignored.
  assign advance  = bus.pause ? bus.step : at_last;
  assign mode_chg = (mode_d != mode_q);

  assign is_onehot = (pattern_q != '0) &&
                     ((pattern_q & (pattern_q - WIDTH'(1))) == '0);

  // Sequencer step for the current mode.
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    next_pattern   = pattern_q;
    next_dir_right = dir_right_q;
    eff_left       = 1'b0;
    shifted        = '0;
    case (mode_d)
      MODE_UP:   next_pattern = pattern_q + WIDTH'(1);
      MODE_DOWN: next_pattern = pattern_q - WIDTH'(1);
      MODE_BOUNCE: begin
        if (!is_onehot) begin
          next_pattern   = WIDTH'(1);
          next_dir_right = 1'b0;
        end else begin
          // A pattern sitting at an end always moves away from it, whatever
          // the stored direction says, so the end value never repeats.
          eff_left = pattern_q[0] | (~pattern_q[WIDTH-1] & ~dir_right_q);
          shifted  = eff_left ? (pattern_q << 1) : (pattern_q >> 1);
          next_pattern = shifted;
          // Direction flips on the advance that lands on an end.
          if (shifted[WIDTH-1])  next_dir_right = 1'b1;
          else if (shifted[0])   next_dir_right = 1'b0;
          else                   next_dir_right = ~eff_left;
        end
      end
      MODE_ROT:  next_pattern = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
    endcase
  end

  // Value loaded when the mode input changes.
  always_comb begin
    reinit_pattern = '0;
    case (mode_d)
      MODE_UP:     reinit_pattern = '0;
      MODE_DOWN:   reinit_pattern = '1;
      MODE_BOUNCE: reinit_pattern = WIDTH'(1);
      MODE_ROT:    reinit_pattern = ROT_INIT;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q       <= '0;
      pattern_q   <= '0;
      dir_right_q <= 1'b0;
      tick_q      <= 1'b0;
      flipper_q   <= 1'b0;
      mode_q      <= MODE_UP;
    end else begin
      mode_q <= mode_d;
      tick_q <= 1'b0;

      // The prescaler keeps its own rhythm; neither a step nor a mode change
      // disturbs it, only pause freezes it.
      if (!bus.pause) begin
        cnt_q <= at_last ? '0 : cnt_q + TICK_W'(1);
      end

      // A mode change reinitialises the pattern and swallows any advance
      // landing on the same edge: no tick, flipper untouched.
      if (mode_chg) begin
        pattern_q <= reinit_pattern;
        if (mode_d == MODE_BOUNCE) begin
          dir_right_q <= 1'b0;
        end
      end else if (advance) begin
        pattern_q   <= next_pattern;
        dir_right_q <= next_dir_right;
        tick_q      <= 1'b1;
        flipper_q   <= ~flipper_q;
      end
    end
  end

  assign bus.pattern = pattern_q;
  assign bus.tick    = tick_q;
  assign bus.flipper = flipper_q;
  assign bus.out     = (bus.override != '0) ? bus.override : pattern_q;

endmodule

// File: tb/tb_pattern_ticker.sv
// -----------------------------------------------------------------------------
// tb_pattern_ticker
//   Two engines share clock, reset and control: dut_a (WIDTH=8, TICKS=4,
//   ROT_INIT=0x81) and dut_b (WIDTH=4, TICKS=1). A behavioural model tracks
//   both each cycle; directed sections exercise the called-out scenarios and a
//   randomized section mixes modes, pause, step, override and reset.
// -----------------------------------------------------------------------------
module tb_pattern_ticker;

  logic clk;
  logic rst;

  pattern_ticker_if #(.WIDTH(8)) ia ();
  pattern_ticker_if #(.WIDTH(4)) ib ();

  pattern_ticker #(
    .WIDTH(8), .TICKS(4), .TICK_W(8), .ROT_INIT(8'h81)
  ) dut_a (
    .CLK(clk), .RST(rst), .bus(ia)
  );

  pattern_ticker #(
    .WIDTH(4), .TICKS(1), .TICK_W(4), .ROT_INIT(4'h1)
  ) dut_b (
    .CLK(clk), .RST(rst), .bus(ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural reference: one call = one clock edge.
  // ---------------------------------------------------------------------------
  typedef struct {
    int unsigned cnt;
    int unsigned pat;
    int unsigned flip;
    int unsigned tick;
    int unsigned dir_r;
    int unsigned mode_q;
  } mstate_t;

  mstate_t sa = '{default: 0};
  mstate_t sb = '{default: 0};

  function automatic mstate_t model_step(input mstate_t s, input int unsigned w,
                                         input int unsigned ticks, input int unsigned rot,
                                         input bit rst_i, input int unsigned mode,
                                         input bit pause, input bit step);
    mstate_t     n    = s;
    int unsigned full = (1 << w) - 1;
    int unsigned top  = 1 << (w - 1);
    bit          adv;
    if (rst_i) begin
      n = '{default: 0};
      return n;
    end
    adv = pause ? step : (s.cnt == ticks - 1);
    if (!pause) n.cnt = (s.cnt + 1) % ticks;
    n.mode_q = mode;
    n.tick   = 0;
    if (mode != s.mode_q) begin
      case (mode)
        0:       n.pat = 0;
        1:       n.pat = full;
        2:       begin n.pat = 1; n.dir_r = 0; end
        default: n.pat = rot;
      endcase
    end else if (adv) begin
      n.tick = 1;
      n.flip = s.flip ^ 1;
      case (mode)
        0: n.pat = (s.pat + 1) & full;
        1: n.pat = (s.pat + full) & full;
        2: begin
          if (s.pat == 0 || (s.pat & (s.pat - 1)) != 0) begin
            n.pat = 1; n.dir_r = 0;
          end else if (s.pat == 1 || (s.dir_r == 0 && s.pat != top)) begin
            n.pat = s.pat * 2; n.dir_r = (n.pat == top) ? 1 : 0;
          end else begin
            n.pat = s.pat / 2; n.dir_r = (n.pat == 1) ? 0 : 1;
          end
        end
        default: n.pat = ((s.pat << 1) | (s.pat >> (w - 1))) & full;
      endcase
    end
    return n;
  endfunction

  // One clock: advance the model with the inputs the DUTs see, then compare.
  task automatic cycle();
    @(posedge clk);
    sa = model_step(sa, 8, 4, 32'h81, rst, ia.mode, ia.pause, ia.step);
    sb = model_step(sb, 4, 1, 32'h1,  rst, ib.mode, ib.pause, ib.step);
    #1;
    check("a_pattern", ia.pattern, sa.pat);
    check("a_tick",    ia.tick,    sa.tick);
    check("a_flipper", ia.flipper, sa.flip);
    check("a_out",     ia.out,     (ia.override != 0) ? ia.override : sa.pat);
    check("b_pattern", ib.pattern, sb.pat);
    check("b_tick",    ib.tick,    sb.tick);
    check("b_flipper", ib.flipper, sb.flip);
    check("b_out",     ib.out,     (ib.override != 0) ? ib.override : sb.pat);
  endtask

  task automatic set_ctrl(input int m, input bit p, input bit s);
    ia.mode = 2'(m); ib.mode = 2'(m);
    ia.pause = p;    ib.pause = p;
    ia.step = s;     ib.step = s;
  endtask

  task automatic wait_tick_a(input int max_cycles);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      cycle();
      seen = ia.tick;
    end
    if (!seen) check("a_tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_cnt_a(input int unsigned value);
    bit hit = (sa.cnt == value);
    for (int i = 0; i < 10 && !hit; i++) begin
      cycle();
      hit = (sa.cnt == value);
    end
    if (!hit) check("a_phase_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int          ticks_seen;
  int unsigned held;
  int unsigned saved_flip;
  int unsigned bounce_exp [7] = '{2, 4, 8, 4, 2, 1, 2};

  initial begin
    rst = 1'b1;
    set_ctrl(0, 1'b0, 1'b0);
    ia.override = '0;
    ib.override = '0;

    // Reset state.
    repeat (2) cycle();
    check("rst_a_pattern", ia.pattern, 32'h0);
    check("rst_a_tick",    ia.tick,    32'h0);
    check("rst_a_flipper", ia.flipper, 32'h0);

    // Count up: ten ticks in 40 cycles, pattern reaches 10.
    rst = 1'b0;
    ticks_seen = 0;
    repeat (40) begin
      cycle();
      ticks_seen += int'(ia.tick);
    end
    check("m0_tick_count", 32'(ticks_seen), 32'd10);
    check("m0_pattern",    ia.pattern,      32'd10);
    check("m0_flipper",    ia.flipper,      32'd0);

    // Count down selected through reset: reinit to all-ones right after release.
    rst = 1'b1;
    set_ctrl(1, 1'b0, 1'b0);
    cycle();
    rst = 1'b0;
    cycle();
    check("m1_reinit",      ia.pattern, 32'hFF);
    check("m1_reinit_tick", ia.tick,    32'h0);
    wait_tick_a(8);
    check("m1_first",  ia.pattern, 32'hFE);
    wait_tick_a(8);
    check("m1_second", ia.pattern, 32'hFD);

    // Count up wrap: all-ones goes to zero.
    set_ctrl(0, 1'b0, 1'b0);
    cycle();
    check("m0_reinit", ia.pattern, 32'h0);
    repeat (255) wait_tick_a(8);
    check("m0_full", ia.pattern, 32'hFF);
    wait_tick_a(8);
    check("m0_wrap", ia.pattern, 32'h00);

    // Bounce on the TICKS=1 engine: 1,2,4,8,4,2,1,2.
    set_ctrl(2, 1'b0, 1'b0);
    cycle();
    check("b_bounce_reinit", ib.pattern, 32'h1);
    for (int i = 0; i < 7; i++) begin
      cycle();
      check("b_bounce_seq", ib.pattern, bounce_exp[i]);
    end

    // Rotate entered on the very edge that would advance: reinit wins.
    wait_cnt_a(3);
    saved_flip = sa.flip;
    set_ctrl(3, 1'b0, 1'b0);
    cycle();
    check("m3_reinit",      ia.pattern, 32'h81);
    check("m3_no_tick",     ia.tick,    32'h0);
    check("m3_flip_stable", ia.flipper, saved_flip);
    wait_tick_a(8);
    check("m3_rot1", ia.pattern, 32'h03);
    wait_tick_a(8);
    check("m3_rot2", ia.pattern, 32'h06);

    // Pause mid-period, single step, resume from the held count.
    set_ctrl(0, 1'b0, 1'b0);
    cycle();
    wait_cnt_a(2);
    held = sa.pat;
    set_ctrl(0, 1'b1, 1'b0);
    ticks_seen = 0;
    repeat (10) begin
      cycle();
      ticks_seen += int'(ia.tick);
    end
    check("pause_no_tick", 32'(ticks_seen), 32'd0);
    check("pause_held",    ia.pattern,      held);
    set_ctrl(0, 1'b1, 1'b1);
    cycle();
    check("step_tick",    ia.tick,    32'h1);
    check("step_pattern", ia.pattern, (held + 1) & 32'hFF);
    set_ctrl(0, 1'b1, 1'b0);
    cycle();
    check("step_single", ia.tick, 32'h0);
    set_ctrl(0, 1'b0, 1'b0);
    cycle();
    check("resume_2to3", ia.tick, 32'h0);
    cycle();
    check("resume_tick",    ia.tick,    32'h1);
    check("resume_pattern", ia.pattern, (held + 2) & 32'hFF);

    // Override replaces the output but not the sequencing.
    ia.override = 8'h5A;
    repeat (12) begin
      cycle();
      check("ovr_out", ia.out, 32'h5A);
    end
    ia.override = '0;
    cycle();
    check("ovr_release", ia.out, sa.pat);

    // Reset in the middle of a bounce.
    set_ctrl(2, 1'b0, 1'b0);
    repeat (7) cycle();
    rst = 1'b1;
    cycle();
    check("rst_bounce_a_out",  ia.out,     32'h0);
    check("rst_bounce_a_tick", ia.tick,    32'h0);
    check("rst_bounce_a_flip", ia.flipper, 32'h0);
    check("rst_bounce_b_out",  ib.out,     32'h0);
    rst = 1'b0;

    // Randomized mix of everything.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        ia.mode = 2'($urandom_range(0, 3));
        ib.mode = ia.mode;
      end
      if ($urandom_range(0, 19) == 0) begin
        ia.pause = ~ia.pause;
        ib.pause = ia.pause;
      end
      ia.step = ($urandom_range(0, 7) == 0);
      ib.step = ia.step;
      ia.override = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
      ib.override = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      rst = ($urandom_range(0, 399) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
